// File: rtl/rs_pkg.sv
// Shared Reed-Solomon package for the RS(204,188) decoder stages.
// Holds the GF(2^8) field constants (primitive poly 0x11D), code sizes, the
// GF multiply function, the constant GF inverse table and the BM FSM state type.
package rs_pkg;

    localparam int unsigned SYM_W  = 8;
    localparam int unsigned T_CAP  = 8;
    localparam int unsigned N_SYND = 2 * T_CAP;
    // Reduction polynomial without the implicit x^8 term.
    localparam logic [SYM_W-1:0] GF_POLY = 8'h1D;

    typedef logic [SYM_W-1:0] sym_t;
    typedef logic [T_CAP:0][SYM_W-1:0] poly_t;

    localparam poly_t POLY_ONE = {{T_CAP{8'h00}}, 8'h01};

    typedef enum logic [1:0] {StIdle, StIter, StFin} bm_state_e;

    // Polynomial-basis multiply with reduction by x^8 + GF_POLY.
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t acc;
        sym_t aa;
        sym_t bb;
        acc = '0;
        aa  = a;
        bb  = b;
        for (int i = 0; i < int'(SYM_W); i++) begin
            if (bb[0]) acc = acc ^ aa;
            aa = aa[SYM_W-1] ? ((aa << 1) ^ GF_POLY) : (aa << 1);
            bb = bb >> 1;
        end
        return acc;
    endfunction

    // Inverse table built from the alpha power sequence: inv(alpha^k) = alpha^(255-k).
    // Entry 0 stays 0.
    function automatic logic [255:0][SYM_W-1:0] gen_inv_table();
        logic [255:0][SYM_W-1:0] tbl;
        logic [255:0][SYM_W-1:0] pw;
        sym_t                    p;
        int                      j;
        tbl = '0;
        pw  = '0;
        p   = 8'h01;
        for (int k = 0; k < 255; k++) begin
            pw[k[7:0]] = p;
            p = gf_mul(p, 8'h02);
        end
        for (int k = 0; k < 255; k++) begin
            j = (255 - k) % 255;
            tbl[pw[k[7:0]]] = pw[j[7:0]];
        end
        return tbl;
    endfunction

    localparam logic [255:0][SYM_W-1:0] GF_INV = gen_inv_table();

endpackage

// File: rtl/rs_berlekamp_massey_if.sv
// Handshake/data bundle between the syndrome stage (master) and the
// Berlekamp-Massey key-equation stage (slave).
//   Start/Synd           : request strobe and S1..S16 (S1 at [7:0])
//   Busy/Done            : run status and one-cycle result strobe
//   Lambda_Out/L_Out/Fail: error locator (Lambda_0 at [7:0]), length, uncorrectable flag
interface rs_berlekamp_massey_if;
    import rs_pkg::*;

    logic                             Start;
    logic [N_SYND*SYM_W-1:0]          Synd;
    logic                             Busy;
    logic                             Done;
    logic [(T_CAP+1)*SYM_W-1:0]       Lambda_Out;
    logic [4:0]                       L_Out;
    logic                             Fail;

    modport master (output Start, Synd, input Busy, Done, Lambda_Out, L_Out, Fail);
    modport slave  (input Start, Synd, output Busy, Done, Lambda_Out, L_Out, Fail);

endinterface

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier (poly 0x11D).
//   a_i, b_i : operands
//   p_o      : product
module gf256_mul
    import rs_pkg::*;
(
    input  sym_t a_i,
    input  sym_t b_i,
    output sym_t p_o
);

    assign p_o = gf_mul(a_i, b_i);

endmodule

// File: rtl/rs_berlekamp_massey.sv
// Berlekamp-Massey key-equation solver, one iteration per clock.
//   Clk   : rising-edge clock
//   Reset : synchronous active-high reset
//   bus   : slave side of rs_berlekamp_massey_if (Start/Synd in;
//           Busy/Done/Lambda_Out/L_Out/Fail out)
// Start in IDLE latches the syndromes; 16 iterations follow, then FIN
// registers the result and pulses Done.
module rs_berlekamp_massey
    import rs_pkg::*;
(
    input logic                  Clk,
    input logic                  Reset,
    rs_berlekamp_massey_if.slave bus
);

    bm_state_e                    state_q, state_d;
    logic [N_SYND-1:0][SYM_W-1:0] s_q;
    poly_t                        lambda_q, b_q;
    logic [4:0]                   l_q, r_q;

    poly_t                        lambda_out_q;
    logic [4:0]                   l_out_q;
    logic                         fail_q, done_q;

    logic                         busy, load_en, iter_en, fin_en;

    poly_t synd_win;   // S[r-i] aligned with Lambda_i, zero where r-i <= 0
    poly_t dprod;      // Lambda_i * S[r-i]
    poly_t xb;         // x*B, top coefficient dropped
    poly_t dxb;        // Delta * x*B
    poly_t binv;       // Delta^-1 * Lambda
    poly_t t_poly;
    sym_t  delta, delta_inv;
    logic  len_change;
    logic  fail_c;

    // ---------------- Datapath (combinational) ----------------
    always_comb begin
        logic [4:0] idx;
        synd_win = '0;
        idx      = '0;
        for (int i = 0; i <= int'(T_CAP); i++) begin
            idx = r_q - 5'(i) - 5'd1;
            if (int'(r_q) > i) synd_win[i] = s_q[idx[3:0]];
        end
    end

    assign xb = {b_q[T_CAP-1:0], 8'h00};

    for (genvar g = 0; g <= T_CAP; g++) begin : g_mul
        gf256_mul u_delta (.a_i(lambda_q[g]), .b_i(synd_win[g]), .p_o(dprod[g]));
        gf256_mul u_dxb   (.a_i(delta),       .b_i(xb[g]),       .p_o(dxb[g]));
        gf256_mul u_binv  (.a_i(delta_inv),   .b_i(lambda_q[g]), .p_o(binv[g]));
    end

    always_comb begin
        delta = '0;
        for (int i = 0; i <= int'(T_CAP); i++) delta = delta ^ dprod[i];
    end

    assign delta_inv  = GF_INV[delta];
    assign t_poly     = lambda_q ^ dxb;
    // 2L <= r-1, evaluated in 6 bits so 2L cannot wrap.
    assign len_change = ({l_q, 1'b0} <= ({1'b0, r_q} - 6'd1));

    // Degree check: L beyond T_CAP cannot be indexed, it is a failure by itself.
    always_comb begin
        fail_c = 1'b0;
        if (l_q > 5'(T_CAP)) fail_c = 1'b1;
        else                 fail_c = (lambda_q[l_q[3:0]] == '0);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.Start) state_d = StIter;
            StIter:  if (r_q == 5'(N_SYND)) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy    = (state_q != StIdle);
        load_en = (state_q == StIdle) && bus.Start;
        iter_en = (state_q == StIter);
        fin_en  = (state_q == StFin);
    end

    // ---------------- Registers ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s_q          <= '0;
            lambda_q     <= '0;
            b_q          <= '0;
            l_q          <= '0;
            r_q          <= '0;
            lambda_out_q <= '0;
            l_out_q      <= '0;
            fail_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= fin_en;
            if (load_en) begin
                s_q      <= bus.Synd;
                lambda_q <= POLY_ONE;
                b_q      <= POLY_ONE;
                l_q      <= '0;
                r_q      <= 5'd1;
            end
            if (iter_en) begin
                r_q <= r_q + 5'd1;
                if (delta != '0) begin
                    lambda_q <= t_poly;
                    if (len_change) begin
                        b_q <= binv;
                        l_q <= r_q - l_q;
                    end else begin
                        b_q <= xb;
                    end
                end else begin
                    b_q <= xb;
                end
            end
            if (fin_en) begin
                lambda_out_q <= lambda_q;
                l_out_q      <= l_q;
                fail_q       <= fail_c;
            end
        end
    end

    assign bus.Busy       = busy;
    assign bus.Done       = done_q;
    assign bus.Lambda_Out = lambda_out_q;
    assign bus.L_Out      = l_out_q;
    assign bus.Fail       = fail_q;

endmodule
